// File: rtl/rob_pkg.sv
// Shared types and constants for the 4-wide reorder buffer.
package rob_pkg;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int SLOTS = 4;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        spec_brch;
    logic        pred;
    logic        taken;
    logic        jr;
    logic        str_en;
    logic [15:0] rcvr_pc;
    logic [15:0] tgt;
  } rob_entry_t;

  // A branch resolved against its prediction, or a jr whose real target
  // differs from the PC fetch assumed.
  function automatic logic mispredict(input rob_entry_t e);
    return (e.spec_brch && (e.taken != e.pred)) ||
           (e.jr && (e.tgt != e.rcvr_pc));
  endfunction

endpackage

// File: rtl/rob_cmt_sel.sv
// In-order retire scan over the four oldest entries; stops at the first
// entry that is not ready, or right after a mispredicting one.
module rob_cmt_sel
  import rob_pkg::*;
(
  input  rob_entry_t  head_ent_i [SLOTS],
  output logic [2:0]  cmt_cnt_o,
  output logic [3:0]  cmt_str_o,
  output logic        flush_o,
  output logic [15:0] flush_pc_o
);

  logic stop;

  always_comb begin
    cmt_cnt_o  = '0;
    cmt_str_o  = '0;
    flush_o    = 1'b0;
    flush_pc_o = '0;
    stop       = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (!stop) begin
        if (head_ent_i[k].valid && head_ent_i[k].done) begin
          cmt_str_o[k] = head_ent_i[k].str_en;
          cmt_cnt_o    = 3'(k + 1);
          if (mispredict(head_ent_i[k])) begin
            flush_o    = 1'b1;
            flush_pc_o = head_ent_i[k].jr ? head_ent_i[k].tgt : head_ent_i[k].rcvr_pc;
            stop       = 1'b1;
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rob.sv
// 4-wide in-order reorder buffer: allocate at tail, complete by index,
// retire up to four from head, flush everything younger on a mispredict.
module rob #(
  parameter int DEPTH = rob_pkg::DEPTH,
  parameter int IDX_W = rob_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         inst_val_in,
  input  logic [63:0]        rcvr_pc_in,
  input  logic [3:0]         str_en_in,
  input  logic [3:0]         spec_brch_in,
  input  logic [3:0]         brch_pred_res_in,
  input  logic [3:0]         no_exe_in,
  input  logic [3:0]         jr_in,
  output logic               alloc_stall_out,
  output logic [4*IDX_W-1:0] alloc_idx_out,
  input  logic [3:0]         cmpl_val_in,
  input  logic [4*IDX_W-1:0] cmpl_idx_in,
  input  logic [3:0]         cmpl_taken_in,
  input  logic [63:0]        cmpl_tgt_in,
  output logic [2:0]         cmt_cnt_out,
  output logic [3:0]         cmt_str_out,
  output logic               flush_out,
  output logic [15:0]        flush_pc_out,
  output logic               empty_out
);
  import rob_pkg::*;

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [IDX_W-1:0] alloc_idx [SLOTS];
  logic [2:0]       pop_n;
  logic [2:0]       alloc_n;
  logic             alloc_en;
  rob_entry_t       head_ent [SLOTS];
  logic [2:0]       cmt_cnt;
  logic             flush;

  assign alloc_stall_out = (count_q > (IDX_W+1)'(DEPTH - SLOTS));
  assign alloc_en        = !alloc_stall_out && !flush;
  assign alloc_n         = alloc_en ? pop_n : 3'd0;
  assign empty_out       = (count_q == '0);
  assign cmt_cnt_out     = cmt_cnt;
  assign flush_out       = flush;

  // Each valid slot lands at tail plus the number of valid slots before it.
  always_comb begin
    pop_n         = '0;
    alloc_idx_out = '0;
    for (int n = 0; n < SLOTS; n++) begin
      alloc_idx[n]                      = tail_q + IDX_W'(pop_n);
      alloc_idx_out[n*IDX_W +: IDX_W]   = alloc_idx[n];
      pop_n                             = pop_n + 3'(inst_val_in[n]);
    end
  end

  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      head_ent[k] = entries_q[head_q + IDX_W'(k)];
    end
  end

  rob_cmt_sel u_cmt_sel (
    .head_ent_i (head_ent),
    .cmt_cnt_o  (cmt_cnt),
    .cmt_str_o  (cmt_str_out),
    .flush_o    (flush),
    .flush_pc_o (flush_pc_out)
  );

  always_comb begin
    entries_d = entries_q;

    // Later ports overwrite earlier ones when they name the same entry.
    for (int p = 0; p < SLOTS; p++) begin
      if (cmpl_val_in[p] && entries_q[cmpl_idx_in[p*IDX_W +: IDX_W]].valid) begin
        entries_d[cmpl_idx_in[p*IDX_W +: IDX_W]].done  = 1'b1;
        entries_d[cmpl_idx_in[p*IDX_W +: IDX_W]].taken = cmpl_taken_in[p];
        entries_d[cmpl_idx_in[p*IDX_W +: IDX_W]].tgt   = cmpl_tgt_in[16*p +: 16];
      end
    end

    for (int k = 0; k < SLOTS; k++) begin
      if (3'(k) < cmt_cnt) begin
        entries_d[head_q + IDX_W'(k)].valid = 1'b0;
        entries_d[head_q + IDX_W'(k)].done  = 1'b0;
      end
    end

    if (alloc_en) begin
      for (int n = 0; n < SLOTS; n++) begin
        if (inst_val_in[n]) begin
          entries_d[alloc_idx[n]] = '{valid:     1'b1,
                                      done:      no_exe_in[n],
                                      spec_brch: spec_brch_in[n],
                                      pred:      brch_pred_res_in[n],
                                      taken:     1'b0,
                                      jr:        jr_in[n],
                                      str_en:    str_en_in[n],
                                      rcvr_pc:   rcvr_pc_in[16*n +: 16],
                                      tgt:       16'h0000};
        end
      end
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end
  end

  always_comb begin
    head_d  = head_q + IDX_W'(cmt_cnt);
    tail_d  = tail_q + IDX_W'(alloc_n);
    count_d = count_q + (IDX_W+1)'(alloc_n) - (IDX_W+1)'(cmt_cnt);
    if (flush) begin
      tail_d  = head_d;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: vector table plus hand sequences; a str_en scoreboard
// follows every allocation through to retirement.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  inst_val, str_en, spec_brch, pred, no_exe, jr;
  logic [63:0] rcvr_pc;
  logic        stall;
  logic [19:0] alloc_idx;
  logic [3:0]  cmpl_val, cmpl_taken;
  logic [19:0] cmpl_idx;
  logic [63:0] cmpl_tgt;
  logic [2:0]  cmt_cnt;
  logic [3:0]  cmt_str;
  logic        flush;
  logic [15:0] flush_pc;
  logic        empty;

  int errors = 0;
  int checks = 0;
  bit sb_q[$];

  always #5 clk = ~clk;

  rob dut (
    .clk              (clk),
    .rst              (rst),
    .inst_val_in      (inst_val),
    .rcvr_pc_in       (rcvr_pc),
    .str_en_in        (str_en),
    .spec_brch_in     (spec_brch),
    .brch_pred_res_in (pred),
    .no_exe_in        (no_exe),
    .jr_in            (jr),
    .alloc_stall_out  (stall),
    .alloc_idx_out    (alloc_idx),
    .cmpl_val_in      (cmpl_val),
    .cmpl_idx_in      (cmpl_idx),
    .cmpl_taken_in    (cmpl_taken),
    .cmpl_tgt_in      (cmpl_tgt),
    .cmt_cnt_out      (cmt_cnt),
    .cmt_str_out      (cmt_str),
    .flush_out        (flush),
    .flush_pc_out     (flush_pc),
    .empty_out        (empty)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  val;
    logic [3:0]  str;
    logic [3:0]  nx;
    logic [19:0] exp_idx;
    logic [2:0]  exp_cnt;
    logic        exp_empty;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    inst_val = '0; str_en = '0; spec_brch = '0; pred = '0; no_exe = '0; jr = '0;
    rcvr_pc = '0; cmpl_val = '0; cmpl_idx = '0; cmpl_taken = '0; cmpl_tgt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt",   32'(cmt_cnt), 32'd0);
    chk("rst_str",   32'(cmt_str), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_fpc",   32'(flush_pc), 32'd0);
    chk("rst_idx",   32'(alloc_idx), 32'd0);
  endtask

  task automatic alloc(input logic [3:0] val, input logic [3:0] str, input logic [3:0] nx,
                       input logic [3:0] sp, input logic [3:0] pr, input logic [3:0] j,
                       input logic [63:0] pcs, input bit accept);
    inst_val = val; str_en = str; no_exe = nx; spec_brch = sp; pred = pr; jr = j;
    rcvr_pc = pcs;
    if (accept) begin
      for (int n = 0; n < 4; n++) if (val[n]) sb_q.push_back(str[n]);
    end
  endtask

  // Retirement monitor: each retired slot must match the oldest queued store flag.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(cmt_cnt)) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: retired slot %0d, nothing expected", k);
          end else begin
            bit e;
            e = sb_q.pop_front();
            chk("sb_cmt_str", 32'(cmt_str[k]), 32'(e));
          end
        end
      end
      if (flush) sb_q.delete();
    end
  end

  initial begin
    logic [15:0] tgts [2];
    rst = 1'b1;
    clr();

    vecs[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 20'd0, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'b1111, 4'b0101, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 3'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 20'd0, 3'd4, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 20'd0, 3'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 20'd0, 3'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'b1010, 4'b1000, 4'b0000, {5'd1, 5'd0, 5'd0, 5'd0}, 3'd0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'b0110, 4'b0010, 4'b0110, {5'd0, 5'd3, 5'd2, 5'd0}, 3'd0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 20'd0, 3'd0, 1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        alloc(vecs[i].val, vecs[i].str, vecs[i].nx, 4'b0, 4'b0, 4'b0, 64'd0, !vecs[i].exp_stall);
        #1;
        chk($sformatf("v%0d_cnt", i),   32'(cmt_cnt), 32'(vecs[i].exp_cnt));
        chk($sformatf("v%0d_empty", i), 32'(empty),   32'(vecs[i].exp_empty));
        chk($sformatf("v%0d_stall", i), 32'(stall),   32'(vecs[i].exp_stall));
        for (int n = 0; n < 4; n++) begin
          if (vecs[i].val[n])
            chk($sformatf("v%0d_idx%0d", i, n), 32'(alloc_idx[5*n +: 5]), 32'(vecs[i].exp_idx[5*n +: 5]));
        end
        tick();
      end
    end

    // Fill to the stall threshold, retire one, then allocate across the wrap.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alloc(4'b1111, 4'(i), 4'b0000, 4'b0, 4'b0, 4'b0, 64'd0, 1'b1);
      #1;
      chk("fill_idx", 32'(alloc_idx[4:0]), 32'(4 * i));
      tick();
    end
    alloc(4'b0001, 4'b0001, 4'b0000, 4'b0, 4'b0, 4'b0, 64'd0, 1'b1);
    #1;
    chk("fill28_stall", 32'(stall), 32'd0);
    chk("fill28_idx",   32'(alloc_idx[4:0]), 32'd28);
    tick();
    alloc(4'b1111, 4'b1111, 4'b0000, 4'b0, 4'b0, 4'b0, 64'd0, 1'b0);
    cmpl_val = 4'b0001;
    cmpl_idx = 20'd0;
    #1;
    chk("fill29_stall", 32'(stall), 32'd1);
    tick();
    #1;
    chk("ret1_cnt",   32'(cmt_cnt), 32'd1);
    chk("ret1_stall", 32'(stall), 32'd1);
    tick();
    alloc(4'b1111, 4'b1001, 4'b0000, 4'b0, 4'b0, 4'b0, 64'd0, 1'b1);
    #1;
    chk("wrap_stall", 32'(stall), 32'd0);
    chk("wrap_idx",   32'(alloc_idx), 32'({5'd0, 5'd31, 5'd30, 5'd29}));
    tick();
    #1;
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_empty", 32'(empty), 32'd0);
    tick();

    // Branch mispredict at idx 0 with done younger entries behind it.
    do_reset();
    alloc(4'b0111, 4'b0010, 4'b0110, 4'b0001, 4'b0001, 4'b0000, {48'd0, 16'h0040}, 1'b1);
    tick();
    cmpl_val   = 4'b0001;
    cmpl_idx   = 20'd0;
    cmpl_taken = 4'b0000;
    #1;
    chk("br_wait_cnt",   32'(cmt_cnt), 32'd0);
    chk("br_wait_flush", 32'(flush), 32'd0);
    tick();
    alloc(4'b0011, 4'b0011, 4'b0011, 4'b0, 4'b0, 4'b0, 64'd0, 1'b0);
    cmpl_val = 4'b0001;
    cmpl_idx = 20'd1;
    #1;
    chk("br_cnt",   32'(cmt_cnt), 32'd1);
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_fpc",   32'(flush_pc), 32'h0040);
    tick();
    alloc(4'b0001, 4'b0000, 4'b0000, 4'b0, 4'b0, 4'b0, 64'd0, 1'b1);
    #1;
    chk("br_post_empty", 32'(empty), 32'd1);
    chk("br_post_cnt",   32'(cmt_cnt), 32'd0);
    chk("br_post_idx",   32'(alloc_idx[4:0]), 32'd1);
    tick();

    // jr at idx 3: a wrong target redirects, a correct one retires quietly.
    tgts[0] = 16'h0200;
    tgts[1] = 16'h0100;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      alloc(4'b1111, 4'b0000, 4'b0111, 4'b0, 4'b0, 4'b1000,
            {16'h0100, 16'h0030, 16'h0020, 16'h0010}, 1'b1);
      #1;
      chk("jr_idx3", 32'(alloc_idx[19:15]), 32'd3);
      tick();
      cmpl_val = 4'b0100;
      cmpl_idx = 20'd3 << 10;
      cmpl_tgt = {16'h0, tgts[t], 32'h0};
      #1;
      chk("jr_pre_cnt",   32'(cmt_cnt), 32'd3);
      chk("jr_pre_flush", 32'(flush), 32'd0);
      tick();
      #1;
      chk("jr_cnt",   32'(cmt_cnt), 32'd1);
      chk("jr_flush", 32'(flush), (tgts[t] != 16'h0100) ? 32'd1 : 32'd0);
      if (tgts[t] != 16'h0100) chk("jr_fpc", 32'(flush_pc), 32'h0200);
      tick();
      #1;
      chk("jr_empty", 32'(empty), 32'd1);
    end

    // Retire gap at entry 1; its two completions disagree and port 3 wins.
    do_reset();
    alloc(4'b1111, 4'b1011, 4'b1101, 4'b0010, 4'b0010, 4'b0000, 64'd0, 1'b1);
    tick();
    cmpl_val   = 4'b1001;
    cmpl_idx   = {5'd1, 5'd0, 5'd0, 5'd1};
    cmpl_taken = 4'b1000;
    #1;
    chk("gap_cnt", 32'(cmt_cnt), 32'd1);
    tick();
    #1;
    chk("gap_after_cnt",   32'(cmt_cnt), 32'd3);
    chk("gap_after_str",   32'(cmt_str), 32'b0101);
    chk("gap_after_flush", 32'(flush), 32'd0);
    tick();
    #1;
    chk("gap_empty", 32'(empty), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- 4-wide in-order reorder buffer that sits directly downstream of the instruction checker.
- Allocates one entry per valid incoming instruction slot, using the per-slot fields the checker produces.
- Records completions from the execution units and retires up to 4 oldest done entries per cycle.
- On a branch/jr mispredict detected at retire: flushes all younger entries and drives the recovery PC to fetch.

Parameters:
- DEPTH, 32, number of entries; power of two.
- IDX_W, 5, log2(DEPTH); width of an entry index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_val_in  in  4  per-slot instruction valid.
- rcvr_pc_in  in  64  4x16-bit recovery PC; slot n at [16n+15:16n].
- str_en_in  in  4  per-slot store flag.
- spec_brch_in  in  4  per-slot speculative branch.
- brch_pred_res_in  in  4  per-slot predicted taken.
- no_exe_in  in  4  per-slot "needs no execution".
- jr_in  in  4  per-slot jump-register.
- alloc_stall_out  out  1  1 when free entries < 4.
- alloc_idx_out  out  4*IDX_W  entry index assigned to each slot; don't-care for invalid slots.
- cmpl_val_in  in  4  completion port valid.
- cmpl_idx_in  in  4*IDX_W  completing entry index.
- cmpl_taken_in  in  4  actual branch outcome.
- cmpl_tgt_in  in  64  4x16 actual jr target.
- cmt_cnt_out  out  3  entries retired this cycle, 0..4.
- cmt_str_out  out  4  retire-slot k is a store; slot 0 is oldest.
- flush_out  out  1  mispredict flush this cycle.
- flush_pc_out  out  16  fetch redirect PC; valid when flush_out=1.
- empty_out  out  1  no occupied entries.

Behaviour:
- Reset:
  - head = 0, tail = 0, count = 0, all entry valid/done bits cleared.
  - Outputs: alloc_stall_out = 0, cmt_cnt_out = 0, cmt_str_out = 0, flush_out = 0, flush_pc_out = 0, empty_out = 1.
- Allocation:
  - Occurs when alloc_stall_out = 0 and no flush is asserted.
  - Valid slots are taken in slot order 0..3 and placed compacted at tail, tail+1, …; indices wrap modulo DEPTH.
  - alloc_idx_out is combinational from the current tail and the prefix popcount of inst_val_in.
  - tail += popcount(inst_val_in).
  - Each new entry stores: rcvr_pc, str_en, spec_brch, pred, jr.
  - done = no_exe_in at allocation; a no_exe entry is retirable the next cycle.
  - While stalled, the input is ignored; upstream holds it.
- Completion:
  - Each valid port sets done = 1 and stores taken and tgt into entry cmpl_idx, at the next edge.
  - Completions targeting non-valid entries are ignored, e.g. a completion arriving the cycle after a flush.
  - Completion and retirement of the same entry in the same cycle: the entry retires the following cycle.
  - Multiple ports naming the same index: the highest-numbered port wins.
- Retire (combinational decision, state updated at edge):
  - Scan head..head+3 in order; stop at the first entry that is not valid or not done.
  - Mispredict condition:
    - spec_brch entry: taken != pred.
    - jr entry: tgt != rcvr_pc.
  - A mispredicting entry retires, and scanning stops after it.
  - cmt_cnt_out = number retired; head += cmt_cnt_out; cmt_str_out[k] = str_en of the k-th retired entry.
- Flush:
  - flush_out = 1 in the cycle the mispredicting entry retires.
  - flush_pc_out = tgt for a jr entry, else rcvr_pc.
  - At that edge: all entries are invalidated, tail = head_new, count = 0.
  - Allocation and completion presented in the flush cycle are discarded.
- Occupancy:
  - count' = count + alloc_n − cmt_cnt; simultaneous allocate and retire are supported.
  - count never exceeds DEPTH; guaranteed by the stall threshold of 4.
  - Wrap-around of head and tail uses natural IDX_W overflow.
- Reset asserted mid-operation: behaves exactly like the reset state; in-flight completions are dropped.

Decomposition:
- Shared package:
  - IDX_W/DEPTH constants.
  - Entry struct: valid, done, spec_brch, pred, taken, jr, str_en, rcvr_pc[15:0], tgt[15:0].
  - Slot count constant 4.
- One natural sub-module: rob_cmt_sel.
  - Combinational 4-deep in-order retire scan.
  - Produces cmt_cnt, cmt_str, flush, and flush_pc from the four head entries.

Test Plan:
- Reset, then 4 valid slots with no_exe = 1111 → alloc_idx = 0,1,2,3; next cycle cmt_cnt = 4; empty_out = 1 one cycle later.
- inst_val = 1010 → slot1 gets idx 0, slot3 gets idx 1; tail = 2.
- Fill to 29 occupied → alloc_stall_out = 1; retire 1 → stall deasserts.
  - Allocation wraps tail 31 → 0 with correct indices.
- Branch at idx 0 with pred = 1, completed taken = 0, rcvr_pc = 0x0040; younger entries at idx 1,2 already done:
  - cmt_cnt = 1, flush_out = 1, flush_pc = 0x0040.
  - Next cycle empty_out = 1; the same-cycle allocation is dropped.
- jr at idx 3 with rcvr_pc = 0x0100, completed tgt = 0x0200 → flush_pc = 0x0200.
  - With tgt = 0x0100 → no flush, normal retire.
- Entries 0..3 where entry 1 is not done → cmt_cnt = 1.
  - Complete entry 1 → next cycle cmt_cnt = 3, cmt_str mirrors str_en in order.
